// File: rtl/cell_cache_select.sv
// Per-core tape-cell cache front end: tag lookup with RMW locking, victim
// selection with optional write-back, and a single-outstanding memory fill port.
module cell_cache_select #(
  parameter int         NENTRIES = 4,
  parameter int         ADDR_W   = 16,
  parameter int         DATA_W   = 16,
  parameter logic [3:0] OP_PLUS  = 4'h1,
  parameter logic [3:0] OP_MINUS = 4'h2,
  parameter logic [3:0] OP_BRZ   = 4'h5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic [3:0]        i_req_op,
  input  logic [ADDR_W-1:0] i_req_ptr,
  output logic              o_req_stall,
  output logic [DATA_W-1:0] o_rsp_data,
  input  logic              i_wb_valid,
  input  logic [ADDR_W-1:0] i_wb_ptr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_wb_err,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_we,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [DATA_W-1:0] o_mem_req_wdata,
  input  logic              i_mem_rsp_valid,
  input  logic [DATA_W-1:0] i_mem_rsp_data
);

  localparam int IDX_W = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_EVICT_WR  = 2'd1;
  localparam logic [1:0] S_FILL_REQ  = 2'd2;
  localparam logic [1:0] S_FILL_WAIT = 2'd3;

  logic [1:0]          r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [NENTRIES-1:0] r_valid;
  logic [NENTRIES-1:0] r_locked;
  logic [NENTRIES-1:0] r_dirty;
  logic [ADDR_W-1:0]   r_tag  [NENTRIES];
  logic [DATA_W-1:0]   r_data [NENTRIES];
  logic                r_fill_busy;
  logic [IDX_W-1:0]    r_fill_idx;
  logic [ADDR_W-1:0]   r_fill_tag;
  logic                r_wb_err;

  logic             w_need;
  logic             w_rmw;
  logic             w_hit_raw;
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_match_any;
  logic             w_pend;
  logic             w_wb_hit;
  logic [IDX_W-1:0] w_wb_idx;
  logic             w_inv_found;
  logic [IDX_W-1:0] w_inv_idx;
  logic             w_rr_found;
  logic [IDX_W-1:0] w_rr_idx;
  logic             w_tgt_found;
  logic [IDX_W-1:0] w_tgt_idx;
  logic             w_tgt_evict;
  logic             w_tgt_dirty;
  logic [IDX_W-1:0] w_rr_next;
  logic [1:0]       w_state_nxt;
  logic             w_start;
  logic             w_evict_done;
  logic             w_fill_done;

  assign w_need = i_req_valid &&
                  ((i_req_op == OP_PLUS) || (i_req_op == OP_MINUS) || (i_req_op == OP_BRZ));
  assign w_rmw  = (i_req_op == OP_PLUS) || (i_req_op == OP_MINUS);
  assign w_pend = r_fill_busy && (r_fill_tag == i_req_ptr);

  // Tag compare for the request and for the write-back port.
  // The entry being evicted is never handed out, so it cannot be locked mid-eviction.
  always_comb begin
    w_hit_raw   = 1'b0;
    w_hit_idx   = '0;
    w_match_any = 1'b0;
    w_wb_hit    = 1'b0;
    w_wb_idx    = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == i_req_ptr)) begin
        w_match_any = 1'b1;
        if (!r_locked[i] && !(r_fill_busy && (r_fill_idx == IDX_W'(i)))) begin
          w_hit_raw = 1'b1;
          w_hit_idx = IDX_W'(i);
        end else begin
          w_hit_raw = w_hit_raw;
        end
      end else begin
        w_match_any = w_match_any;
      end
      if (r_valid[i] && r_locked[i] && (r_tag[i] == i_wb_ptr)) begin
        w_wb_hit = 1'b1;
        w_wb_idx = IDX_W'(i);
      end else begin
        w_wb_hit = w_wb_hit;
      end
    end
  end

  assign w_hit       = w_need && w_hit_raw;
  assign o_req_stall = w_need && !w_hit_raw;
  assign o_rsp_data  = w_hit ? r_data[w_hit_idx] : '0;
  assign o_wb_err    = r_wb_err;

  // Target choice: lowest invalid entry, else round-robin over unlocked valid entries.
  always_comb begin : victim_sel
    int j;
    j           = 0;
    w_inv_found = 1'b0;
    w_inv_idx   = '0;
    w_rr_found  = 1'b0;
    w_rr_idx    = '0;
    for (int i = NENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_inv_found = 1'b1;
        w_inv_idx   = IDX_W'(i);
      end else begin
        w_inv_found = w_inv_found;
      end
    end
    for (int k = NENTRIES - 1; k >= 0; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NENTRIES) begin
        j = j - NENTRIES;
      end else begin
        j = j;
      end
      if (r_valid[j] && !r_locked[j]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IDX_W'(j);
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  assign w_tgt_found = w_inv_found || w_rr_found;
  assign w_tgt_idx   = w_inv_found ? w_inv_idx : w_rr_idx;
  assign w_tgt_evict = !w_inv_found;
  assign w_tgt_dirty = !w_inv_found && r_dirty[w_rr_idx];
  assign w_rr_next   = (w_rr_idx == IDX_W'(NENTRIES - 1)) ? '0 : (w_rr_idx + IDX_W'(1));

  // Miss FSM next state and memory request port decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_start         = 1'b0;
    w_evict_done    = 1'b0;
    w_fill_done     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_we    = 1'b0;
    o_mem_req_addr  = '0;
    o_mem_req_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_need && !w_match_any && !w_pend && w_tgt_found) begin
          w_start     = 1'b1;
          w_state_nxt = w_tgt_dirty ? S_EVICT_WR : S_FILL_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EVICT_WR: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_we    = 1'b1;
        o_mem_req_addr  = r_tag[r_fill_idx];
        o_mem_req_wdata = r_data[r_fill_idx];
        if (i_mem_req_ready) begin
          w_evict_done = 1'b1;
          w_state_nxt  = S_FILL_REQ;
        end else begin
          w_state_nxt = S_EVICT_WR;
        end
      end
      S_FILL_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = r_fill_tag;
        if (i_mem_req_ready) begin
          w_state_nxt = S_FILL_WAIT;
        end else begin
          w_state_nxt = S_FILL_REQ;
        end
      end
      S_FILL_WAIT: begin
        if (i_mem_rsp_valid) begin
          w_fill_done = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FILL_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Entry array, fill tracker, round-robin pointer and wb error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_valid     <= '0;
      r_locked    <= '0;
      r_dirty     <= '0;
      r_fill_busy <= 1'b0;
      r_fill_idx  <= '0;
      r_fill_tag  <= '0;
      r_wb_err    <= 1'b0;
      for (int i = 0; i < NENTRIES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_wb_err <= i_wb_valid && !w_wb_hit;
      if (w_hit && w_rmw) begin
        r_locked[w_hit_idx] <= 1'b1;
      end
      if (i_wb_valid && w_wb_hit) begin
        r_data[w_wb_idx]   <= i_wb_data;
        r_locked[w_wb_idx] <= 1'b0;
        r_dirty[w_wb_idx]  <= 1'b1;
      end
      if (w_start) begin
        r_fill_busy <= 1'b1;
        r_fill_idx  <= w_tgt_idx;
        r_fill_tag  <= i_req_ptr;
        if (w_tgt_evict) begin
          r_rr_ptr <= w_rr_next;
        end
        // A clean victim is dropped now; a dirty one stays until its write-back lands.
        if (w_tgt_evict && !w_tgt_dirty) begin
          r_valid[w_tgt_idx] <= 1'b0;
        end
      end
      if (w_evict_done) begin
        r_valid[r_fill_idx] <= 1'b0;
        r_dirty[r_fill_idx] <= 1'b0;
      end
      if (w_fill_done) begin
        r_valid[r_fill_idx]  <= 1'b1;
        r_locked[r_fill_idx] <= 1'b0;
        r_dirty[r_fill_idx]  <= 1'b0;
        r_tag[r_fill_idx]    <= r_fill_tag;
        r_data[r_fill_idx]   <= i_mem_rsp_data;
        r_fill_busy          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cell_cache_select.sv
// Directed + randomized bench for cell_cache_select: a latency-programmable memory
// model plus a golden "value the core should see" map per tape address.
module tb_cell_cache_select;

  localparam logic [3:0] OP_PLUS  = 4'h1;
  localparam logic [3:0] OP_MINUS = 4'h2;
  localparam logic [3:0] OP_BRZ   = 4'h5;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [3:0]  i_req_op = 4'h0;
  logic [15:0] i_req_ptr = 16'h0;
  logic        o_req_stall;
  logic [15:0] o_rsp_data;
  logic        i_wb_valid = 1'b0;
  logic [15:0] i_wb_ptr = 16'h0;
  logic [15:0] i_wb_data = 16'h0;
  logic        o_wb_err;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready = 1'b1;
  logic        o_mem_req_we;
  logic [15:0] o_mem_req_addr;
  logic [15:0] o_mem_req_wdata;
  logic        i_mem_rsp_valid = 1'b0;
  logic [15:0] i_mem_rsp_data = 16'h0;

  cell_cache_select dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_op(i_req_op), .i_req_ptr(i_req_ptr),
    .o_req_stall(o_req_stall), .o_rsp_data(o_rsp_data),
    .i_wb_valid(i_wb_valid), .i_wb_ptr(i_wb_ptr), .i_wb_data(i_wb_data), .o_wb_err(o_wb_err),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_we(o_mem_req_we), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_wdata(o_mem_req_wdata),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;
  int lat       = 3;
  int ready_low = 0;

  logic [15:0] bmem [logic [15:0]];
  logic [15:0] gold [logic [15:0]];
  logic        lg_we   [$];
  logic [15:0] lg_addr [$];
  logic [15:0] lg_data [$];

  function automatic logic [15:0] bmem_val(input logic [15:0] a);
    if (!bmem.exists(a)) bmem[a] = 16'($urandom);
    return bmem[a];
  endfunction

  function automatic logic [15:0] gold_val(input logic [15:0] a);
    if (gold.exists(a)) return gold[a];
    return bmem_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: logs handshakes, checks hold-while-not-ready, returns reads after lat cycles.
  initial begin : mem_model
    logic        hold_prev;
    logic        h_we;
    logic [15:0] h_addr, h_wdata, rdata;
    logic        pend;
    int          cnt;
    hold_prev = 1'b0; h_we = 1'b0; h_addr = 16'h0; h_wdata = 16'h0;
    rdata = 16'h0; pend = 1'b0; cnt = 0;
    forever begin
      @(negedge i_clk);
      if (hold_prev && !i_rst) begin
        chk("hold_valid", 32'(o_mem_req_valid), 32'd1);
        chk("hold_we", 32'(o_mem_req_we), 32'(h_we));
        chk("hold_addr", 32'(o_mem_req_addr), 32'(h_addr));
        chk("hold_wdata", 32'(o_mem_req_wdata), 32'(h_wdata));
      end
      hold_prev = o_mem_req_valid && !i_mem_req_ready && !i_rst;
      h_we = o_mem_req_we; h_addr = o_mem_req_addr; h_wdata = o_mem_req_wdata;
      if (o_mem_req_valid && i_mem_req_ready && !i_rst) begin
        lg_we.push_back(o_mem_req_we);
        lg_addr.push_back(o_mem_req_addr);
        lg_data.push_back(o_mem_req_wdata);
        if (o_mem_req_we) begin
          chk("evict_value", 32'(o_mem_req_wdata), 32'(gold_val(o_mem_req_addr)));
          bmem[o_mem_req_addr] = o_mem_req_wdata;
        end else begin
          pend = 1'b1; cnt = lat; rdata = bmem_val(o_mem_req_addr);
        end
      end
      @(posedge i_clk); #2;
      i_mem_rsp_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          i_mem_rsp_valid = 1'b1; i_mem_rsp_data = rdata; pend = 1'b0;
        end
      end
      if (ready_low > 0) begin
        i_mem_req_ready = 1'b0; ready_low--;
      end else begin
        i_mem_req_ready = 1'b1;
      end
    end
  end

  task automatic clear_log();
    lg_we.delete(); lg_addr.delete(); lg_data.delete();
  endtask

  task automatic chk_log_entry(input string tag, input int k, input logic we, input logic [15:0] a);
    if (lg_addr.size() > k) begin
      chk({tag, "_we"}, 32'(lg_we[k]), 32'(we));
      chk({tag, "_addr"}, 32'(lg_addr[k]), 32'(a));
    end
  endtask

  task automatic wait_unstall(input string tag, output int stalls, output logic [15:0] data);
    bit done;
    done = 1'b0; stalls = 0; data = 16'h0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (!o_req_stall) begin
        data = o_rsp_data; done = 1'b1; break;
      end
      stalls++;
      @(posedge i_clk); #1;
    end
    chk({tag, "_unstall_in_time"}, 32'(done), 32'd1);
  endtask

  // One core access; exp_stalls < 0 means the stall count is not checked.
  task automatic access(input logic [3:0] op, input logic [15:0] ptr,
                        input int exp_stalls, input string tag);
    int st;
    logic [15:0] d;
    i_req_valid = 1'b1; i_req_op = op; i_req_ptr = ptr;
    wait_unstall(tag, st, d);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    chk({tag, "_data"}, 32'(d), 32'(gold_val(ptr)));
    if (exp_stalls >= 0) chk({tag, "_stalls"}, 32'(st), 32'(exp_stalls));
  endtask

  task automatic do_wb(input logic [15:0] ptr, input logic [15:0] data,
                       input logic exp_err, input string tag);
    i_wb_valid = 1'b1; i_wb_ptr = ptr; i_wb_data = data;
    @(posedge i_clk); #1;
    i_wb_valid = 1'b0;
    if (!exp_err) gold[ptr] = data;
    @(negedge i_clk);
    chk({tag, "_err"}, 32'(o_wb_err), 32'(exp_err));
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk({tag, "_err_clear"}, 32'(o_wb_err), 32'd0);
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_req_valid = 1'b0; i_wb_valid = 1'b0;
    gold.delete();
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic fill_1_to_4();
    for (int a = 1; a <= 4; a++) access(OP_BRZ, 16'(a), 2 + lat, "fill");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int st;
    logic [15:0] d, v;
    bmem[16'h0010] = 16'h00AB;

    // Reset state
    @(negedge i_clk); @(negedge i_clk);
    chk("rst_stall", 32'(o_req_stall), 32'd0);
    chk("rst_rsp_data", 32'(o_rsp_data), 32'd0);
    chk("rst_wb_err", 32'(o_wb_err), 32'd0);
    chk("rst_mem_valid", 32'(o_mem_req_valid), 32'd0);
    chk("rst_mem_we", 32'(o_mem_req_we), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_req_addr), 32'd0);
    chk("rst_mem_wdata", 32'(o_mem_req_wdata), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Cold BRZ: miss, one read, unstall at miss + 2 + L, entry left unlocked
    clear_log();
    access(OP_BRZ, 16'h0010, 2 + lat, "t1_cold");
    chk("t1_log_len", 32'(lg_addr.size()), 32'd1);
    chk_log_entry("t1_rd", 0, 1'b0, 16'h0010);
    access(OP_BRZ, 16'h0010, 0, "t1_rehit");

    // PLUS locks; second PLUS stalls until wb, same-cycle wb still stalls
    access(OP_PLUS, 16'h0010, 0, "t2_plus1");
    i_req_valid = 1'b1; i_req_op = OP_PLUS; i_req_ptr = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      chk("t2_locked_stall", 32'(o_req_stall), 32'd1);
      chk("t2_no_mem", 32'(o_mem_req_valid), 32'd0);
      @(posedge i_clk); #1;
    end
    i_wb_valid = 1'b1; i_wb_ptr = 16'h0010; i_wb_data = 16'h00AC;
    @(negedge i_clk);
    chk("t2_same_cycle_stall", 32'(o_req_stall), 32'd1);
    @(posedge i_clk); #1;
    i_wb_valid = 1'b0;
    gold[16'h0010] = 16'h00AC;
    @(negedge i_clk);
    chk("t2_after_wb_stall", 32'(o_req_stall), 32'd0);
    chk("t2_after_wb_data", 32'(o_rsp_data), 32'h00AC);
    chk("t2_wb_ok", 32'(o_wb_err), 32'd0);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;

    // Dirty eviction: write-back of 0x1 precedes read of 0x5, rr_ptr moves to 1
    do_reset();
    fill_1_to_4();
    access(OP_PLUS, 16'h0001, 0, "t3_lock1");
    v = 16'($urandom);
    do_wb(16'h0001, v, 1'b0, "t3_wb1");
    clear_log();
    access(OP_BRZ, 16'h0005, 3 + lat, "t3_miss5");
    chk("t3_log_len", 32'(lg_addr.size()), 32'd2);
    chk_log_entry("t3_wr", 0, 1'b1, 16'h0001);
    chk_log_entry("t3_rd", 1, 1'b0, 16'h0005);
    clear_log();
    access(OP_BRZ, 16'h0006, 2 + lat, "t3_miss6");
    chk("t3_clean_log_len", 32'(lg_addr.size()), 32'd1);
    chk_log_entry("t3_rd6", 0, 1'b0, 16'h0006);
    access(OP_BRZ, 16'h0003, 0, "t3_hit3");
    access(OP_BRZ, 16'h0004, 0, "t3_hit4");
    access(OP_BRZ, 16'h0005, 0, "t3_hit5");
    access(OP_BRZ, 16'h0006, 0, "t3_hit6");

    // All entries locked: miss waits with no memory traffic until one is released
    do_reset();
    fill_1_to_4();
    for (int a = 1; a <= 4; a++) access(OP_PLUS, 16'(a), 0, "t4_lock");
    clear_log();
    i_req_valid = 1'b1; i_req_op = OP_BRZ; i_req_ptr = 16'h0009;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      chk("t4_all_locked_stall", 32'(o_req_stall), 32'd1);
      chk("t4_all_locked_no_mem", 32'(o_mem_req_valid), 32'd0);
      @(posedge i_clk); #1;
    end
    v = 16'($urandom);
    i_wb_valid = 1'b1; i_wb_ptr = 16'h0002; i_wb_data = v;
    @(posedge i_clk); #1;
    i_wb_valid = 1'b0;
    gold[16'h0002] = v;
    wait_unstall("t4", st, d);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    chk("t4_stalls", 32'(st), 32'(3 + lat));
    chk("t4_data", 32'(d), 32'(gold_val(16'h0009)));
    chk("t4_log_len", 32'(lg_addr.size()), 32'd2);
    chk_log_entry("t4_wr", 0, 1'b1, 16'h0002);
    chk_log_entry("t4_rd", 1, 1'b0, 16'h0009);

    // Ready held low for 5 cycles during a dirty eviction; then wb to uncached address
    do_reset();
    fill_1_to_4();
    access(OP_PLUS, 16'h0001, 0, "t5_lock1");
    do_wb(16'h0001, 16'($urandom), 1'b0, "t5_wb1");
    clear_log();
    ready_low = 5;
    access(OP_BRZ, 16'h0020, 7 + lat, "t5_slow");
    chk_log_entry("t5_wr", 0, 1'b1, 16'h0001);
    chk_log_entry("t5_rd", 1, 1'b0, 16'h0020);
    do_wb(16'h0077, 16'h1234, 1'b1, "t5_wb_uncached");

    // Reset during FILL_WAIT: late response ignored, cache comes back empty
    do_reset();
    access(OP_BRZ, 16'h0040, 2 + lat, "t6_pre");
    i_req_valid = 1'b1; i_req_op = OP_BRZ; i_req_ptr = 16'h0030;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("t6_fill_req_valid", 32'(o_mem_req_valid), 32'd1);
    chk("t6_fill_req_addr", 32'(o_mem_req_addr), 32'h0030);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_rst = 1'b1; i_req_valid = 1'b0;
    gold.delete();
    #1;
    chk("t6_rst_mem_valid", 32'(o_mem_req_valid), 32'd0);
    chk("t6_rst_stall", 32'(o_req_stall), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("t6_late_rsp_no_mem", 32'(o_mem_req_valid), 32'd0);
    @(posedge i_clk); #1;
    clear_log();
    access(OP_BRZ, 16'h0040, 2 + lat, "t6_refetch40");
    access(OP_BRZ, 16'h0030, 2 + lat, "t6_fresh30");
    chk("t6_log_len", 32'(lg_addr.size()), 32'd2);
    chk_log_entry("t6_rd40", 0, 1'b0, 16'h0040);
    chk_log_entry("t6_rd30", 1, 1'b0, 16'h0030);

    // Randomized traffic over a small address pool with random latency and back-pressure
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      int kind;
      a = 16'h0100 + 16'($urandom_range(0, 5));
      kind = $urandom_range(0, 4);
      lat = $urandom_range(1, 4);
      ready_low = $urandom_range(0, 2);
      if (kind == 0) begin
        access(OP_BRZ, a, -1, "rnd_brz");
      end else if (kind == 1) begin
        access(OP_PLUS, a, -1, "rnd_plus");
        do_wb(a, gold_val(a) + 16'd1, 1'b0, "rnd_plus_wb");
      end else if (kind == 2) begin
        access(OP_MINUS, a, -1, "rnd_minus");
        do_wb(a, gold_val(a) - 16'd1, 1'b0, "rnd_minus_wb");
      end else if (kind == 3) begin
        i_req_valid = 1'b1; i_req_op = 4'h3; i_req_ptr = a;
        @(negedge i_clk);
        chk("rnd_other_op_no_stall", 32'(o_req_stall), 32'd0);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
      end else begin
        do_wb(16'hF000 + 16'($urandom_range(0, 255)), 16'($urandom), 1'b1, "rnd_bad_wb");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cell_cache_select.md
# cell_cache_select

Per-core tape-cell cache front end for the multi-core tape machine. Looks up the cell addressed by the core's data pointer in a private tag store of NENTRIES entries, returns its value, locks it for read-modify-write ops (PLUS/MINUS) until the core writes it back, and on a miss evicts (with write-back if dirty) and fills from memory over a ready/valid port with arbitrary latency. Sits between the core decode stage and the shared memory arbiter.

## Interface
- NENTRIES, 4, cache entries (≥2)
- ADDR_W, 16, tape address width
- DATA_W, 16, cell width
- OP_PLUS, 4'h1; OP_MINUS, 4'h2; OP_BRZ, 4'h5, opcodes needing a cell
- clk  in  1  clock; one clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core presents an instruction
- req_op  in  4  instruction opcode (ins[15:12])
- req_ptr  in  ADDR_W  data pointer
- req_stall  out  1  core must hold req_* this cycle
- rsp_data  out  DATA_W  cell value, valid when req_valid & need & !req_stall
- wb_valid  in  1  core returns a modified cell, releasing its lock
- wb_ptr  in  ADDR_W  address being returned
- wb_data  in  DATA_W  new value
- wb_err  out  1  one-cycle pulse: wb to an address not present-and-locked
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write-back, 0 = fill read
- mem_req_addr  out  ADDR_W
- mem_req_wdata  out  DATA_W
- mem_rsp_valid  in  1  fill data returned (reads only)
- mem_rsp_data  in  DATA_W

## Operation
- Entry state: {valid, locked, dirty, tag, data}; plus one fill-in-flight register {busy, index, tag}.
- need = req_valid & op ∈ {PLUS, MINUS, BRZ}. Other ops: req_stall=0, no state change.
- Hit (valid, tag==req_ptr, !locked): req_stall=0, rsp_data=entry data combinationally; at edge locked←1 for PLUS/MINUS, unchanged for BRZ.
- Locked hit, or tag matches in-flight fill: req_stall=1, no memory activity.
- Miss: req_stall=1; FSM starts a fill.
- FSM states: IDLE → (victim dirty) EVICT_WR → FILL_REQ → FILL_WAIT → IDLE.
  - IDLE, miss: target = lowest-index invalid entry; if none, victim = first valid unlocked entry searching from rr_ptr upward with wrap; rr_ptr ← victim+1 mod NENTRIES. No candidate (all locked): stay IDLE, keep stalling.
  - EVICT_WR: mem_req_valid=1, we=1, addr=victim tag, wdata=victim data; on ready: victim valid←0, → FILL_REQ.
  - FILL_REQ: mem_req_valid=1, we=0, addr=req_ptr; on ready: → FILL_WAIT.
  - FILL_WAIT: on mem_rsp_valid: entry ← {valid=1, locked=0, dirty=0, tag, mem_rsp_data}, → IDLE.
- wb_valid with matching valid+locked entry: data←wb_data, locked←0, dirty←1. Otherwise: no change, wb_err=1 next cycle.
- wb and req to same address in one cycle: req sees pre-wb state (stalls); hits next cycle with new data.
- mem_req_* held stable while valid & !ready. mem_rsp_valid outside FILL_WAIT ignored.
- Only one memory transaction outstanding.

## Timing
- Reset (async assert, sync-released at next edge): all entries invalid/unlocked/clean, rr_ptr=0, FSM IDLE, req_stall=need-dependent (0 when req_valid=0), mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, rsp_data=0 when no hit, wb_err=0.
- Reset mid-fill or mid-evict: transaction abandoned; late mem_rsp_valid ignored.
- Hit latency 0 cycles (combinational); lock visible next cycle.
- Clean miss, ready=1, memory latency L: mem_req_valid asserted cycle after miss; data written on rsp cycle; request un-stalls the cycle after rsp. Dirty miss adds one cycle per write handshake.
- wb_err asserted exactly one cycle, the cycle after the offending wb.

## Test plan
- Cold BRZ at ptr 0x0010, L=3, ready=1: one read to 0x0010, rsp 0x00AB → stall released, rsp_data=0xAB, entry unlocked.
- PLUS at 0x0010 (hit) then PLUS 0x0010 next cycle: second stalls until wb(0x0010, 0x00AC), then returns 0x00AC.
- NENTRIES=4, fill 0x1–0x4, wb dirty on 0x1, miss 0x5: write(0x1, value) precedes read 0x5; rr_ptr=1 after.
- All four entries locked, miss 0x9: no mem_req_valid while locked; wb on 0x2 → eviction of 0x2 proceeds.
- mem_req_ready low 5 cycles: addr/we/wdata stable throughout; wb to uncached 0x77 → wb_err pulse one cycle.
- Assert rst during FILL_WAIT, then mem_rsp_valid: ignored; all entries invalid; subsequent BRZ misses afresh.
